// File: rtl/ifu_swc.sv
// Instruction fetch unit: issues word fetches, tracks in-flight responses and
// buffers returned instructions in order for the decoder.
module ifu_swc #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IBUF_DEPTH = 2
) (
    input  logic        hclk,
    input  logic        hrstn,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        dec_ready,
    output logic [31:0] ifu_inst,
    output logic [31:0] ifu_pc,
    output logic        ifu_dec_stall
);

    localparam int unsigned PW      = $clog2(IBUF_DEPTH);
    localparam int unsigned CW      = $clog2(IBUF_DEPTH + 1);
    localparam logic [CW:0]   DEPTH_C = (CW + 1)'(IBUF_DEPTH);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [31:0]   NOP     = 32'h0000_0013;

    logic [31:0]   fetch_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [CW-1:0] buf_cnt;
    logic [PW-1:0] pq_wr, pq_rd, buf_wr, buf_rd;

    logic [31:0] pq_mem   [IBUF_DEPTH];
    logic [31:0] buf_pc   [IBUF_DEPTH];
    logic [31:0] buf_inst [IBUF_DEPTH];

    logic [CW:0]   occupancy;
    logic [CW-1:0] outstanding_next;
    logic          grant, resp, push, pop;

    always_comb begin
        occupancy        = {1'b0, outstanding} + {1'b0, buf_cnt};
        imem_req         = hrstn && (occupancy < DEPTH_C);
        imem_addr        = fetch_pc;
        grant            = imem_req && imem_gnt;
        resp             = imem_rvalid && (outstanding != '0);
        push             = resp && (discard == '0) && !redirect_valid;
        pop              = (buf_cnt != '0) && dec_ready && !redirect_valid;
        outstanding_next = outstanding + CW'(grant) - CW'(resp);
        ifu_dec_stall    = (buf_cnt == '0);
        ifu_inst         = ifu_dec_stall ? NOP : buf_inst[buf_rd];
        ifu_pc           = ifu_dec_stall ? '0  : buf_pc[buf_rd];
    end

    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            buf_cnt     <= '0;
            pq_wr       <= '0;
            pq_rd       <= '0;
            buf_wr      <= '0;
            buf_rd      <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (grant) pq_wr <= pq_wr + PTR_ONE;
            if (resp)  pq_rd <= pq_rd + PTR_ONE;

            if (redirect_valid) begin
                fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
            end else if (grant) begin
                fetch_pc <= fetch_pc + 32'd4;
            end

            // Everything still in flight after this cycle belongs to the old path.
            if (redirect_valid) begin
                discard <= outstanding_next;
            end else if (resp && (discard != '0)) begin
                discard <= discard - CW'(1);
            end

            if (redirect_valid) begin
                buf_cnt <= '0;
                buf_wr  <= '0;
                buf_rd  <= '0;
            end else begin
                if (push) buf_wr <= buf_wr + PTR_ONE;
                if (pop)  buf_rd <= buf_rd + PTR_ONE;
                buf_cnt <= buf_cnt + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (grant) pq_mem[pq_wr] <= fetch_pc;
        if (push) begin
            buf_pc[buf_wr]   <= pq_mem[pq_rd];
            buf_inst[buf_wr] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_ifu_swc.sv
// Randomized scoreboard bench for ifu_swc with an epoch-based fetch model.
module tb_ifu_swc;

    localparam int unsigned DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0040;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        hclk = 1'b0;
    logic        hrstn;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_ready;
    logic [31:0] ifu_inst;
    logic [31:0] ifu_pc;
    logic        ifu_dec_stall;

    ifu_swc #(.RESET_PC(RST_PC), .IBUF_DEPTH(DEPTH)) dut (
        .hclk(hclk), .hrstn(hrstn),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .dec_ready(dec_ready),
        .ifu_inst(ifu_inst), .ifu_pc(ifu_pc), .ifu_dec_stall(ifu_dec_stall)
    );

    always #5 hclk = ~hclk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    typedef struct {
        logic [31:0] addr;
        int unsigned epoch;
        int unsigned due;
    } req_t;

    ent_t exp_q[$];
    req_t mem_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_0F1E;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h required=%08h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares the presented instruction with the scoreboard head.
    initial begin
        forever begin
            @(negedge hclk);
            #2;
            if (!hrstn || exp_q.size() == 0) begin
                check("stall_empty", 32'(ifu_dec_stall), 32'd1);
                check("inst_empty", ifu_inst, NOP);
                check("pc_empty", ifu_pc, 32'd0);
            end else begin
                check("stall_valid", 32'(ifu_dec_stall), 32'd0);
                check("ifu_pc", ifu_pc, exp_q[0].pc);
                check("ifu_inst", ifu_inst, exp_q[0].inst);
                if (dec_ready && !redirect_valid) void'(exp_q.pop_front());
            end
        end
    end

    // Driver and reference model: a response is kept only if it was granted in the
    // current redirect epoch and does not coincide with a redirect.
    initial begin
        logic [31:0] m_pc;
        int unsigned epoch;
        int unsigned mode;
        logic        rst;
        logic        exp_req;
        req_t        r;

        m_pc = RST_PC;
        epoch = 0;
        hrstn = 1'b0;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = '0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        dec_ready = 1'b0;

        for (int unsigned c = 0; c < 720; c++) begin
            @(negedge hclk);
            rst  = (c < 4) || (c >= 300 && c < 304);
            mode = (c < 40) ? 2 : (c < 70) ? 1 : (c < 600) ? 0 : 2;
            hrstn = !rst;

            if (mode == 2) begin
                imem_gnt = 1'b1; dec_ready = 1'b1; redirect_valid = 1'b0;
            end else if (mode == 1) begin
                imem_gnt = 1'b1; dec_ready = 1'b0; redirect_valid = 1'b0;
            end else begin
                imem_gnt       = ($urandom_range(0, 9) < 7);
                dec_ready      = ($urandom_range(0, 9) < 6);
                redirect_valid = ($urandom_range(0, 19) == 0);
            end
            case ($urandom_range(0, 3))
                0:       redirect_pc = 32'h0000_1002;
                1:       redirect_pc = 32'hFFFF_FFF8;
                2:       redirect_pc = 32'hFFFF_FFFE;
                default: redirect_pc = $urandom;
            endcase
            if (c == 620) begin redirect_valid = 1'b1; redirect_pc = 32'h0000_1002; end
            if (c == 660) begin redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8; end

            if (rst) begin
                imem_rvalid = ($urandom_range(0, 1) == 1);
                imem_rdata  = $urandom;
            end else if (mem_q.size() > 0 && mem_q[0].due <= c &&
                         (mode == 2 || $urandom_range(0, 9) < 6)) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(mem_q[0].addr);
            end else if (mem_q.size() == 0 && mode == 0 && $urandom_range(0, 9) == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = $urandom;
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = $urandom;
            end

            #1;
            exp_req = hrstn && ((mem_q.size() + exp_q.size()) < DEPTH);
            check("imem_req", 32'(imem_req), 32'(exp_req));
            if (exp_req && imem_req) check("imem_addr", imem_addr, m_pc);

            #3;
            if (!hrstn) begin
                mem_q.delete();
                exp_q.delete();
                m_pc = RST_PC;
                epoch++;
            end else begin
                if (imem_rvalid && mem_q.size() > 0) begin
                    r = mem_q.pop_front();
                    if (r.epoch == epoch && !redirect_valid)
                        exp_q.push_back('{pc: r.addr, inst: mem_word(r.addr)});
                end
                if (exp_req && imem_gnt) begin
                    mem_q.push_back('{addr: m_pc, epoch: epoch,
                                      due: c + 1 + ((mode == 2) ? 0 : $urandom_range(0, 3))});
                    m_pc = m_pc + 32'd4;
                end
                if (redirect_valid) begin
                    exp_q.delete();
                    epoch++;
                    m_pc = {redirect_pc[31:2], 2'b00};
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
